// File: rtl/tc_bus_pkg.sv
// Shared op and state encodings for the TC register bus master and the decoder feeding it.
package tc_bus_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 16;

    localparam logic [OP_W-1:0] OP_MOVE      = 2'd0;
    localparam logic [OP_W-1:0] OP_WRITE_IMM = 2'd1;
    localparam logic [OP_W-1:0] OP_READ      = 2'd2;
    localparam logic [OP_W-1:0] OP_RSVD      = 2'd3;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_SAVE = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd3;

    // Which index fields an opcode actually consumes (for range checking).
    function automatic logic op_uses_src(input logic [OP_W-1:0] op);
        return (op == OP_MOVE) || (op == OP_READ);
    endfunction

    function automatic logic op_uses_dst(input logic [OP_W-1:0] op);
        return (op == OP_MOVE) || (op == OP_WRITE_IMM);
    endfunction

endpackage

// File: rtl/tc_onehot_decode.sv
// Index-to-one-hot decoder with enable; out-of-range indices decode to all zeros.
module tc_onehot_decode #(
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_OUT)
) (
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_register_bus_master.sv
// Command-driven initiator owning the load/save strobes and shared write bus of a TC register bank.
module tc_register_bus_master
    import tc_bus_pkg::*;
#(
    parameter int unsigned  NUM_REGS  = 8,
    parameter int unsigned  BIT_WIDTH = 8,
    localparam int unsigned IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OP_W-1:0]               cmd_op,
    input  logic [IDX_W-1:0]              cmd_src,
    input  logic [IDX_W-1:0]              cmd_dst,
    input  logic [BIT_WIDTH-1:0]          cmd_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [BIT_WIDTH-1:0]          resp_data,
    output logic [NUM_REGS-1:0]           reg_load,
    output logic [NUM_REGS-1:0]           reg_save,
    output logic [BIT_WIDTH-1:0]          reg_in,
    input  logic [NUM_REGS*BIT_WIDTH-1:0] reg_out,
    output logic                          err,
    output logic [CNT_W-1:0]              op_count
);

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(NUM_REGS);

    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_next;
    logic [OP_W-1:0]      op_q;
    logic [IDX_W-1:0]     src_q;
    logic [IDX_W-1:0]     dst_q;
    logic [BIT_WIDTH-1:0] hold_q;
    logic [BIT_WIDTH-1:0] resp_q;
    logic                 resp_first_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 handshake;
    logic                 cmd_bad;
    logic                 accept;
    logic                 cnt_inc;
    logic                 load_en;
    logic                 save_en;
    logic [IDX_W-1:0]     load_idx;
    logic [IDX_W-1:0]     save_idx;
    logic [NUM_REGS-1:0]  load_next_c;
    logic [NUM_REGS-1:0]  save_next_c;
    logic [BIT_WIDTH-1:0] src_word;
    logic [BIT_WIDTH-1:0] words [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_words
        assign words[g] = reg_out[g*BIT_WIDTH +: BIT_WIDTH];
    end

    assign src_word = words[src_q];

    // Next state plus the next-cycle strobe selection and completion bookkeeping.
    always_comb begin
        state_next = state;
        handshake  = 1'b0;
        cmd_bad    = 1'b0;
        accept     = 1'b0;
        cnt_inc    = 1'b0;
        load_idx   = src_q;
        save_idx   = dst_q;

        case (state)
            ST_IDLE: begin
                handshake = cmd_valid;
                cmd_bad   = (cmd_op == OP_RSVD)
                          || (op_uses_src(cmd_op) && ({1'b0, cmd_src} >= IDX_LIMIT))
                          || (op_uses_dst(cmd_op) && ({1'b0, cmd_dst} >= IDX_LIMIT));
                accept    = handshake && !cmd_bad;
                load_idx  = cmd_src;
                save_idx  = cmd_dst;
                if (accept) begin
                    state_next = (cmd_op == OP_WRITE_IMM) ? ST_SAVE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = (op_q == OP_READ) ? ST_RESP : ST_SAVE;
            end
            ST_SAVE: begin
                state_next = ST_IDLE;
                cnt_inc    = 1'b1;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                    cnt_inc    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        load_en = (state_next == ST_LOAD);
        save_en = (state_next == ST_SAVE);
    end

    tc_onehot_decode #(
        .NUM_OUT (NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_load_dec (
        .en       (load_en),
        .idx      (load_idx),
        .onehot_c (load_next_c)
    );

    tc_onehot_decode #(
        .NUM_OUT (NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_save_dec (
        .en       (save_en),
        .idx      (save_idx),
        .onehot_c (save_next_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= OP_MOVE;
            src_q        <= '0;
            dst_q        <= '0;
            hold_q       <= '0;
            resp_q       <= '0;
            resp_first_q <= 1'b0;
            cnt_q        <= '0;
            cmd_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            reg_load     <= '0;
            reg_save     <= '0;
            err          <= 1'b0;
        end else begin
            state        <= state_next;
            cmd_ready    <= (state_next == ST_IDLE);
            resp_valid   <= (state_next == ST_RESP);
            reg_load     <= load_next_c;
            reg_save     <= save_next_c;
            err          <= handshake && cmd_bad;
            resp_first_q <= (state == ST_LOAD) && (state_next == ST_RESP);

            if (accept) begin
                op_q  <= cmd_op;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
            end

            if (accept && (cmd_op == OP_WRITE_IMM)) begin
                hold_q <= cmd_data;
            end else if ((state == ST_SAVE) && (op_q == OP_MOVE)) begin
                hold_q <= src_word;
            end

            if (resp_first_q) begin
                resp_q <= src_word;
            end

            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // The source register's out only settles at the edge that enters SAVE/RESP,
    // so the first cycle of each forwards it directly instead of a stale copy.
    assign reg_in    = ((state == ST_SAVE) && (op_q == OP_MOVE)) ? src_word : hold_q;
    assign resp_data = resp_first_q ? src_word : resp_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_tc_register_bus_master.sv
// Scoreboard bench for tc_register_bus_master driving a behavioural TC register bank.
module tb_tc_register_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [7:0]  cmd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [7:0]  reg_load;
    logic [7:0]  reg_save;
    logic [7:0]  reg_in;
    logic [63:0] reg_out;
    logic        err;
    logic [15:0] op_count;

    // Second instance with a non-power-of-two bank for index range checks.
    logic        c2_valid;
    logic        c2_ready;
    logic [1:0]  c2_op;
    logic [2:0]  c2_src;
    logic [2:0]  c2_dst;
    logic [7:0]  c2_data;
    logic        c2_resp_valid;
    logic [7:0]  c2_resp_data;
    logic [5:0]  c2_load;
    logic [5:0]  c2_save;
    logic [7:0]  c2_reg_in;
    logic [47:0] c2_reg_out;
    logic        c2_err;
    logic [15:0] c2_count;

    int n_checks = 0;
    int n_pass   = 0;
    int save_seen = 0;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;

    logic [7:0] store [8];
    logic [7:0] outw  [8];

    tc_register_bus_master #(.NUM_REGS(8), .BIT_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .reg_load   (reg_load),
        .reg_save   (reg_save),
        .reg_in     (reg_in),
        .reg_out    (reg_out),
        .err        (err),
        .op_count   (op_count)
    );

    tc_register_bus_master #(.NUM_REGS(6), .BIT_WIDTH(8)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (c2_valid),
        .cmd_ready  (c2_ready),
        .cmd_op     (c2_op),
        .cmd_src    (c2_src),
        .cmd_dst    (c2_dst),
        .cmd_data   (c2_data),
        .resp_valid (c2_resp_valid),
        .resp_ready (1'b1),
        .resp_data  (c2_resp_data),
        .reg_load   (c2_load),
        .reg_save   (c2_save),
        .reg_in     (c2_reg_in),
        .reg_out    (c2_reg_out),
        .err        (c2_err),
        .op_count   (c2_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural TC_Register bank: out updates on load at posedge, save captures at negedge.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (reg_load[i]) outw[i] <= store[i];
    end
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) if (reg_save[i]) store[i] <= reg_in;
    end
    always_comb begin
        for (int i = 0; i < 8; i++) reg_out[i*8 +: 8] = outw[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Strobe legality monitor.
    always @(negedge clk) begin
        if (|reg_save) save_seen++;
        if ((|reg_load) || (|reg_save)) begin
            chk("strobe_legal",
                32'($onehot0(reg_load) && $onehot0(reg_save) && !((|reg_load) && (|reg_save))), 32'd1);
        end
    end

    // Response scoreboard: compares each accepted READ result with the queued expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_data", 32'(resp_data), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns in the cycle after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] data);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] dst, input logic [7:0] data);
        send(2'd1, 3'd0, dst, data);
        chk("wr_save", 32'(reg_save), 32'(8'd1 << dst));
        chk("wr_reg_in", 32'(reg_in), 32'(data));
        chk("wr_no_load", 32'(reg_load), 32'd0);
        step();
        exp_cnt++;
        chk("wr_op_count", 32'(op_count), 32'(exp_cnt));
        chk("wr_save_clear", 32'(reg_save), 32'd0);
    endtask

    task automatic do_move(input logic [2:0] src, input logic [2:0] dst, input logic [7:0] val);
        send(2'd0, src, dst, 8'h00);
        chk("mv_load", 32'(reg_load), 32'(8'd1 << src));
        chk("mv_no_save", 32'(reg_save), 32'd0);
        step();
        chk("mv_save", 32'(reg_save), 32'(8'd1 << dst));
        chk("mv_no_load", 32'(reg_load), 32'd0);
        chk("mv_reg_in", 32'(reg_in), 32'(val));
        step();
        exp_cnt++;
        chk("mv_op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    task automatic do_read(input logic [2:0] src, input logic [7:0] val);
        exp_q.push_back(val);
        send(2'd2, src, 3'd0, 8'h00);
        chk("rd_load", 32'(reg_load), 32'(8'd1 << src));
        chk("rd_resp_early", 32'(resp_valid), 32'd0);
        step();
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        exp_cnt++;
        chk("rd_op_count", 32'(op_count), 32'(exp_cnt));
        chk("rd_resp_done", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 8; i++) begin
            store[i] = 8'h00;
            outw[i]  = 8'h00;
        end
        c2_reg_out = '0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_data = 8'h00;
        resp_ready = 1'b1;
        c2_valid = 1'b0; c2_op = 2'd0; c2_src = 3'd0; c2_dst = 3'd0; c2_data = 8'h00;
        exp_cnt = 16'd0;
        step(); step(); step();
        rst = 1'b0;

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_strobes", 32'({reg_load, reg_save}), 32'd0);
        chk("rst_reg_in", 32'(reg_in), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);

        do_write(3'd3, 8'hA5);
        do_read(3'd3, 8'hA5);
        chk("op_count_two", 32'(op_count), 32'd2);
        do_move(3'd3, 3'd5, 8'hA5);
        do_read(3'd5, 8'hA5);
        do_write(3'd0, 8'h3C);
        do_move(3'd0, 3'd0, 8'h3C);
        do_read(3'd0, 8'h3C);
        do_write(3'd7, 8'h81);
        do_read(3'd7, 8'h81);

        // Stalled response with a queued command waiting behind it.
        resp_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send(2'd2, 3'd5, 3'd0, 8'h00);
        chk("st_load", 32'(reg_load), 32'h20);
        step();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 3'd2; cmd_data = 8'h77;
        for (int k = 0; k < 10; k++) begin
            chk("st_resp_valid", 32'(resp_valid), 32'd1);
            chk("st_resp_data", 32'(resp_data), 32'hA5);
            chk("st_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("st_no_save", 32'(reg_save), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        exp_cnt++;
        chk("st_op_count", 32'(op_count), 32'(exp_cnt));
        chk("st_ready_after", 32'(cmd_ready), 32'd1);
        chk("st_not_yet", 32'(reg_save), 32'd0);
        step();
        cmd_valid = 1'b0;
        chk("st_next_save", 32'(reg_save), 32'h04);
        chk("st_next_reg_in", 32'(reg_in), 32'h77);
        step();
        exp_cnt++;
        chk("st_next_count", 32'(op_count), 32'(exp_cnt));

        // Reserved opcode.
        send(2'd3, 3'd1, 3'd2, 8'h55);
        chk("rsvd_err", 32'(err), 32'd1);
        chk("rsvd_strobes", 32'({reg_load, reg_save}), 32'd0);
        step();
        chk("rsvd_err_pulse", 32'(err), 32'd0);
        chk("rsvd_count", 32'(op_count), 32'(exp_cnt));
        chk("rsvd_idle", 32'(cmd_ready), 32'd1);

        // Out-of-range destination on a 6-register bank, then a legal one.
        c2_valid = 1'b1; c2_op = 2'd1; c2_dst = 3'd7; c2_data = 8'h11;
        step();
        c2_valid = 1'b0;
        chk("oor_err", 32'(c2_err), 32'd1);
        chk("oor_strobes", 32'({c2_load, c2_save}), 32'd0);
        step();
        chk("oor_err_pulse", 32'(c2_err), 32'd0);
        chk("oor_count", 32'(c2_count), 32'd0);
        c2_valid = 1'b1; c2_op = 2'd1; c2_dst = 3'd5; c2_data = 8'h22;
        step();
        c2_valid = 1'b0;
        chk("n6_save", 32'(c2_save), 32'h20);
        chk("n6_err", 32'(c2_err), 32'd0);
        step();
        chk("n6_count", 32'(c2_count), 32'd1);

        // Reset during the LOAD cycle of a MOVE.
        send(2'd0, 3'd5, 3'd6, 8'h00);
        chk("rm_load", 32'(reg_load), 32'h20);
        snap = save_seen;
        rst = 1'b1;
        step();
        chk("rm_save", 32'(reg_save), 32'd0);
        chk("rm_load_clr", 32'(reg_load), 32'd0);
        chk("rm_resp", 32'({resp_valid, err}), 32'd0);
        chk("rm_resp_data", 32'(resp_data), 32'd0);
        chk("rm_reg_in", 32'(reg_in), 32'd0);
        chk("rm_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        exp_cnt = 16'd0;
        step();
        chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        step(); step();
        chk("rm_no_late_save", 32'(save_seen), 32'(snap));
        chk("rm_store6", 32'(store[6]), 32'h00);

        // Counter wrap.
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        step();
        exp_cnt = 16'hFFFF;
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        do_write(3'd1, 8'h5A);
        chk("wrap_zero", 32'(op_count), 32'd0);

        step(); step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tc_register_bus_master.md
# tc_register_bus_master

Command-driven initiator for a bank of `TC_Register`-style storage elements. It owns the `load`/`save` strobes and the shared write-data bus for up to NUM_REGS registers, executes MOVE, WRITE_IMM and READ commands over a valid/ready handshake, and returns READ results on a response channel. It sits between a sequencer/decoder and the register bank, replacing hand-wired strobe logic.

## Interface
- NUM_REGS, 8: registers on the bus, 2..64.
- BIT_WIDTH, 8: data width of each register.
- IDX_W, $clog2(NUM_REGS): index width (derived, not overridden).
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset rst, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=MOVE, 1=WRITE_IMM, 2=READ, 3=reserved.
- cmd_src  in  IDX_W  source index (MOVE, READ).
- cmd_dst  in  IDX_W  destination index (MOVE, WRITE_IMM).
- cmd_data  in  BIT_WIDTH  immediate (WRITE_IMM).
- resp_valid  out  1  READ result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  BIT_WIDTH  READ result, stable while resp_valid.
- reg_load  out  NUM_REGS  one-hot/zero load strobes.
- reg_save  out  NUM_REGS  one-hot/zero save strobes.
- reg_in  out  BIT_WIDTH  shared write-data bus to all register `in` ports.
- reg_out  in  NUM_REGS*BIT_WIDTH  concatenated register outputs, reg i at [i*BIT_WIDTH +: BIT_WIDTH].
- err  out  1  one-cycle pulse on a rejected command.
- op_count  out  16  completed-command counter, wraps.

## Operation
- States: IDLE, LOAD, SAVE, RESP.
- IDLE: cmd_ready=1. Handshake = cmd_valid & cmd_ready at posedge; command fields are latched.
  - MOVE -> LOAD. WRITE_IMM -> SAVE with hold = cmd_data. READ -> LOAD.
  - op 3, or any used index >= NUM_REGS -> err pulse next cycle, stay IDLE, no strobes, op_count unchanged.
- LOAD (1 cycle): reg_load[src]=1. Register `out` updates at the closing posedge. Next -> MOVE: SAVE; READ: RESP.
- SAVE (1 cycle): hold captures reg_out[src] on entry for MOVE. reg_in=hold, reg_save[dst]=1; the register captures it at the mid-cycle negedge. -> IDLE, op_count+1.
- RESP: resp_valid=1, resp_data=reg_out[src] captured on entry. Exit on resp_ready -> IDLE, op_count+1.
- MOVE with src==dst is legal: the value is reloaded and re-saved unchanged.
- At most one bit of reg_load and one of reg_save high per cycle. Both strobe vectors are never high in the same cycle.
- reg_in carries hold in every state. Its value matters only in SAVE.

## Timing
- Reset values: state IDLE, cmd_ready=1 after reset deasserts, resp_valid=0, resp_data=0, reg_load=0, reg_save=0, reg_in=0, err=0, op_count=0.
- rst has priority in any state. A command in flight is abandoned with no strobe in the following cycle. No partial save is issued after the rst cycle.
- Latency from accept cycle: WRITE_IMM saves in cycle +1. MOVE loads in +1 and saves in +2. READ loads in +1 and resp_valid asserts in +2.
- Back-to-back throughput: one command per 2 cycles (WRITE_IMM), 3 (MOVE), or ≥3 (READ).
- resp_valid is held with resp_data stable until resp_ready. resp_ready outside RESP is ignored.
- op_count increments in the cycle the command completes (SAVE exit or RESP handshake), wraps 0xFFFF->0.

## Structure
- Shared package `tc_bus_pkg`: op encodings (OP_MOVE, OP_WRITE_IMM, OP_READ, OP_RSVD) and state encoding. The same constants are reused by the future decoder driving cmd_*.
- Sub-module `tc_onehot_decode` (IDX_W -> NUM_REGS with enable) generates reg_load and reg_save. It is instantiated twice.
- Top-level bank wrapper (outside this block) ties N `TC_Register` instances to reg_load/reg_save/reg_in/reg_out.

## Test plan
- Reset, then WRITE_IMM dst=3 data=0xA5 -> reg_save=0x08 exactly one cycle after accept with reg_in=0xA5. READ src=3 -> reg_load=0x08 then resp_data=0xA5, op_count=2.
- MOVE src=3 dst=5 after the preceding step -> reg_load=0x08 in cycle +1, reg_save=0x20 with reg_in=0xA5 in cycle +2. A subsequent READ 5 returns 0xA5.
- READ with resp_ready held low 10 cycles -> resp_valid and resp_data stay constant, cmd_ready=0 throughout, and the next command is accepted only after the handshake.
- cmd_op=3, and with NUM_REGS=6 a dst=7 -> err pulses once each, no strobes, op_count unchanged.
- rst asserted in the LOAD cycle of a MOVE -> no reg_save ever issued, all outputs at reset values next cycle, op_count=0.
- Preload op_count=0xFFFF via 65535 WRITE_IMMs, or force it in sim -> the next completion wraps it to 0.
